fifo_wr_packer: RTL and testbench

Write-domain width upsizer that sits directly upstream of the async FIFO's write port. It accepts narrow beats over a valid/ready handshake and packs RATIO consecutive beats into one wide word with a per-lane keep mask. Words close early on an end-of-packet marker or after an idle timeout. The packed word, keep mask and last flag drive the FIFO's write data; m_valid/m_ready map to w_valid/w_ready.

---
 rtl/async_fifo_package.sv | 17 +
 rtl/flush_timer.sv | 30 +++
 rtl/fifo_wr_packer.sv | 122 ++++++++++++
 tb/tb_fifo_wr_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_package.sv
// Shared definitions for the async FIFO write path: packer state type and
// helper functions used to size and mask the packed write word.
package async_fifo_package;

    typedef enum logic {PK_EMPTY, PK_FILL} pk_state_t;

    // Width of a packed word built from ratio beats of in_w bits.
    function automatic int packed_width(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    // Mask with lanes 0..n set (n is a lane index, not a count).
    function automatic logic [31:0] keep_mask(input int n);
        return (32'd2 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/flush_timer.sv
// Saturating idle counter; expired flags the idle edge that reaches TIMEOUT
// and stays high while the count is parked at TIMEOUT.
module flush_timer #(
    parameter  int TIMEOUT = 16,
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // The TIMEOUT-th idle edge itself may carry the flush, so look one count ahead.
    assign expired = (TIMEOUT != 0) &&
                     ((count == TW'(TIMEOUT)) || (enable && (count == TW'(TIMEOUT - 1))));

endmodule

// File: rtl/fifo_wr_packer.sv
// Write-domain upsizer: packs RATIO narrow beats into one wide FIFO word with
// a keep mask, closing early on s_last or after an idle timeout.
module fifo_wr_packer
    import async_fifo_package::*;
#(
    parameter  int IN_WIDTH  = 8,
    parameter  int RATIO     = 4,
    parameter  int TIMEOUT   = 16,
    localparam int OUT_WIDTH = packed_width(IN_WIDTH, RATIO)
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 s_valid,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic [RATIO-1:0]     m_keep,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam int CW = $clog2(RATIO);

    // Handshake: a beat transfers on s_valid & s_ready, a word on m_valid & m_ready;
    // s_ready depends only on the output slot, never on s_valid or s_last.

    pk_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IN_WIDTH-1:0]  lane_q [RATIO-1];

    logic                 accept;
    logic                 closing;
    logic                 timer_expired;
    logic                 flush_fire;
    logic                 load;
    logic [OUT_WIDTH-1:0] nxt_data;
    logic [RATIO-1:0]     nxt_keep;
    logic                 nxt_last;

    assign s_ready    = ~m_valid | m_ready;
    assign accept     = s_valid & s_ready;
    assign closing    = accept & ((cnt == CW'(RATIO - 1)) | s_last);
    assign flush_fire = timer_expired & (state == PK_FILL) & ~accept & s_ready;
    assign load       = closing | flush_fire;

    flush_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_flush_timer (
        .clk     (wclk),
        .rst     (wrst),
        .clear   (accept | flush_fire | (state == PK_EMPTY)),
        .enable  ((state == PK_FILL) & ~accept),
        .expired (timer_expired)
    );

    always_comb begin
        nxt_data = '0;
        nxt_keep = '0;
        nxt_last = closing & s_last;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (CW'(i) < cnt) begin
                nxt_data[i*IN_WIDTH +: IN_WIDTH] = lane_q[i];
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (closing && (cnt == CW'(i))) begin
                nxt_data[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
        // A flush carries only the lanes already accumulated, never lane cnt.
        if (closing) begin
            nxt_keep = RATIO'(keep_mask(int'(cnt)));
        end else if (cnt != '0) begin
            nxt_keep = RATIO'(keep_mask(int'(cnt) - 1));
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state   <= PK_EMPTY;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            for (int i = 0; i < RATIO - 1; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                if (closing) begin
                    cnt   <= '0;
                    state <= PK_EMPTY;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (cnt == CW'(i)) begin
                            lane_q[i] <= s_data;
                        end
                    end
                    cnt   <= cnt + 1'b1;
                    state <= PK_FILL;
                end
            end else if (flush_fire) begin
                cnt   <= '0;
                state <= PK_EMPTY;
            end

            // A new word may replace a draining one in the same cycle.
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= nxt_data;
                m_keep  <= nxt_keep;
                m_last  <= nxt_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer: a list-based packet model predicts
// words into exp_q; an independent monitor pops and compares on each transfer.
module tb_fifo_wr_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int TO = 8;
    localparam int OW = IW * R;
    localparam int EW = 1 + R + OW;

    logic          wclk;
    logic          wrst;
    logic          s_valid;
    logic [IW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic [R-1:0]  m_keep;
    logic          m_last;
    logic          m_ready;

    fifo_wr_packer #(
        .IN_WIDTH (IW),
        .RATIO    (R),
        .TIMEOUT  (TO)
    ) dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_ready (m_ready)
    );

    // ---------------- clock / reset ----------------
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    logic [IW-1:0] cur_q[$];
    int            m_idle = 0;

    task automatic emit(input logic l);
        logic [OW-1:0] d;
        logic [R-1:0]  k;
        d = '0;
        k = '0;
        foreach (cur_q[i]) begin
            d = d | (OW'(cur_q[i]) << (IW * i));
            k[i] = 1'b1;
        end
        exp_q.push_back({l, k, d});
        cur_q.delete();
        m_idle = 0;
    endtask

    // Sampled just before each rising edge: what the packer commits at that edge.
    always @(negedge wclk) begin
        #4;
        if (!wrst) begin
            if (s_valid && s_ready) begin
                cur_q.push_back(s_data);
                m_idle = 0;
                if (cur_q.size() == R || s_last) emit(s_last);
            end else if (cur_q.size() > 0) begin
                m_idle++;
                if (m_idle >= TO && s_ready) emit(1'b0);
            end
        end
    end

    // ---------------- monitor ----------------
    logic          hold_v = 1'b0;
    logic [EW:0]   hold_val;

    always @(negedge wclk) begin
        #4;
        if (!wrst) begin
            chk("s_ready_rule", s_ready, !m_valid || m_ready);
            if (hold_v) chk("held_stable", {m_valid, m_last, m_keep, m_data}, hold_val);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL word_unexpected: got %0h expected none at %0t",
                             {m_last, m_keep, m_data}, $time);
                end else begin
                    chk("word", {m_last, m_keep, m_data}, exp_q.pop_front());
                end
            end
            hold_v   = m_valid && !m_ready;
            hold_val = {m_valid, m_last, m_keep, m_data};
        end
    end

    // ---------------- drivers ----------------
    int   rdy_mode    = 0;
    logic fixed_ready = 1'b1;

    task automatic upd_ready();
        case (rdy_mode)
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = fixed_ready;
        endcase
    endtask

    task automatic send(input logic [IW-1:0] d, input logic l);
        int tries;
        tries = 0;
        @(negedge wclk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        upd_ready();
        #4;
        while (!s_ready) begin
            tries++;
            if (tries > 100) begin
                n_checks++;
                n_err++;
                $display("FAIL send_timeout: got s_ready 0 expected 1 within 100 cycles");
                break;
            end
            @(negedge wclk);
            upd_ready();
            #4;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge wclk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            upd_ready();
            #4;
        end
    endtask

    task automatic pulse_reset();
        @(negedge wclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1 wrst = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_cnt", dut.cnt, 0);
        cur_q.delete();
        exp_q.delete();
        m_idle = 0;
        hold_v = 1'b0;
        #1 wrst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wrst    = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_keep", m_keep, 0);
        chk("reset_m_last", m_last, 1'b0);
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_cnt", dut.cnt, 0);
        #12 wrst = 1'b0;

        // Full word, checked one cycle after the fourth accept.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        idle(1);
        chk("full_latency", m_valid, 1'b1);

        // Short packet closed by s_last.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        idle(2);

        // Idle flush after TO idle edges.
        send(8'h5A, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            idle(1);
            if (k == 8) chk("flush_not_early", m_valid, 1'b0);
            if (k == 9) chk("flush_on_time", m_valid, 1'b1);
        end
        idle(1);

        // Beat on the last idle cycle appends instead of flushing.
        send(8'h5A, 1'b0);
        idle(7);
        send(8'h5B, 1'b0);
        idle(1);
        chk("append_no_flush", m_valid, 1'b0);
        send(8'h5C, 1'b1);
        idle(2);

        // Held word: stalled for 20 cycles, then back-to-back replacement.
        fixed_ready = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        repeat (20) begin
            @(negedge wclk);
            s_valid = 1'b1;
            s_data  = 8'hD1;
            s_last  = 1'b1;
            upd_ready();
            #4;
            chk("held_s_ready", s_ready, 1'b0);
        end
        fixed_ready = 1'b1;
        @(negedge wclk);
        upd_ready();
        #4;
        chk("release_s_ready", s_ready, 1'b1);
        idle(1);
        chk("back_to_back_valid", m_valid, 1'b1);
        idle(2);

        // Eight beats with m_ready toggling every cycle.
        rdy_mode = 1;
        for (int i = 1; i <= 8; i++) send(IW'(i), 1'b0);
        rdy_mode = 0;
        idle(4);

        // Reset mid-packet discards the partial word.
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        pulse_reset();
        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b0);
        idle(3);

        // Randomized traffic with gaps long enough to hit the timeout.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
            send(IW'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
        end
        rdy_mode    = 0;
        fixed_ready = 1'b1;
        idle(30);
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
